// File: rtl/shifter_pkg.sv
// shifter_pkg: mode encodings and pipeline depth helper for the barrel shifter
package shifter_pkg;
   localparam logic [2:0] MODE_SRL = 3'b000;
   localparam logic [2:0] MODE_SRA = 3'b001;
   localparam logic [2:0] MODE_SLL = 3'b010;
   localparam logic [2:0] MODE_SLA = 3'b011;
   localparam logic [2:0] MODE_ROR = 3'b100;
   localparam logic [2:0] MODE_ROL = 3'b101;
   function automatic int stage_count(input int shamt_w, input int reg_every);
      return (shamt_w + reg_every - 1) / reg_every;
   endfunction
endpackage

// File: rtl/shifter_level.sv
// shifter_level: one combinational shift/rotate level by a fixed distance
module shifter_level import shifter_pkg::*; #(
   parameter int WIDTH = 32,
   parameter int DIST  = 1
) (
   input  logic [WIDTH-1:0] data,
   input  logic [2:0]       mode,
   input  logic             en,
   output logic [WIDTH-1:0] y
);
   logic [WIDTH-1:0] sra, sh;
   assign sra = WIDTH'($signed(data) >>> DIST);
   always_comb
      sh = (mode == MODE_SRL) ? data >> DIST :
           (mode == MODE_SRA) ? sra :
           (mode == MODE_SLL || mode == MODE_SLA) ? data << DIST :
           (mode == MODE_ROR) ? {data[DIST-1:0], data[WIDTH-1:DIST]} :
           (mode == MODE_ROL) ? {data[WIDTH-DIST-1:0], data[WIDTH-1:WIDTH-DIST]} :
           data;
   assign y = en ? sh : data;
endmodule

// File: rtl/shifter_pipe.sv
// shifter_pipe: pipelined log-depth barrel shifter with valid/ready backpressure
module shifter_pipe import shifter_pkg::*; #(
   parameter int WIDTH     = 32,
   parameter int SHAMT_W   = $clog2(WIDTH),
   parameter int REG_EVERY = 2,
   parameter int TAG_W     = 5
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               flush_in,
   input  logic               in_valid,
   output logic               in_ready,
   input  logic [2:0]         mode_in,
   input  logic [SHAMT_W-1:0] shamt_in,
   input  logic [WIDTH-1:0]   a_in,
   input  logic [TAG_W-1:0]   tag_in,
   output logic               out_valid,
   input  logic               out_ready,
   output logic [WIDTH-1:0]   out_data,
   output logic [TAG_W-1:0]   out_tag
);
   localparam int L = stage_count(SHAMT_W, REG_EVERY);
   logic               v     [L];
   logic [WIDTH-1:0]   d_q   [L];
   logic [2:0]         m_q   [L];
   logic [SHAMT_W-1:0] s_q   [L];
   logic [TAG_W-1:0]   t_q   [L];
   logic               src_v [L];
   logic [WIDTH-1:0]   src_d [L];
   logic [2:0]         src_m [L];
   logic [SHAMT_W-1:0] src_s [L];
   logic [TAG_W-1:0]   src_t [L];
   logic [WIDTH-1:0]   stg   [L];
   logic [WIDTH-1:0]   lvl   [SHAMT_W];
   logic [L-1:0]       rdy;
   genvar j, k;
   generate
      for (j = 0; j < L; j++) begin : g_stage
         localparam int E = ((j + 1) * REG_EVERY < SHAMT_W ? (j + 1) * REG_EVERY : SHAMT_W) - 1;
         if (j == 0) begin : g_in
            assign src_v[j] = in_valid;
            assign src_d[j] = a_in;
            assign src_m[j] = mode_in;
            assign src_s[j] = shamt_in;
            assign src_t[j] = tag_in;
         end else begin : g_prev
            assign src_v[j] = v[j-1];
            assign src_d[j] = d_q[j-1];
            assign src_m[j] = m_q[j-1];
            assign src_s[j] = s_q[j-1];
            assign src_t[j] = t_q[j-1];
         end
         assign stg[j] = lvl[E];
      end
      for (k = 0; k < SHAMT_W; k++) begin : g_lvl
         localparam int J = k / REG_EVERY;
         logic [WIDTH-1:0] li;
         // the first level of each group starts from that group's stage input
         if (k % REG_EVERY == 0) begin : g_first
            assign li = src_d[J];
         end else begin : g_chain
            assign li = lvl[k-1];
         end
         shifter_level #(.WIDTH(WIDTH), .DIST(1 << k)) u_lvl (
            .data (li),
            .mode (src_m[J]),
            .en   (src_s[J][k]),
            .y    (lvl[k])
         );
      end
   endgenerate
   always_comb begin
      rdy = '0;
      rdy[L-1] = out_ready || !v[L-1];
      for (int i = L - 2; i >= 0; i--) rdy[i] = rdy[i+1] || !v[i];
   end
   always_ff @(posedge clk or posedge rst) begin
      for (int i = 0; i < L; i++) begin
         if (rst) begin
            v[i]   <= 1'b0;
            d_q[i] <= '0;
            m_q[i] <= '0;
            s_q[i] <= '0;
            t_q[i] <= '0;
         end else if (flush_in) begin
            v[i]   <= 1'b0;
         end else if (rdy[i]) begin
            v[i]   <= src_v[i];
            d_q[i] <= stg[i];
            m_q[i] <= src_m[i];
            s_q[i] <= src_s[i];
            t_q[i] <= src_t[i];
         end
      end
   end
   assign in_ready  = rdy[0];
   assign out_valid = v[L-1];
   assign out_data  = d_q[L-1];
   assign out_tag   = t_q[L-1];
endmodule

// File: tb/tb_shifter_pipe.sv
// tb_shifter_pipe: directed and randomized checks of shifter_pipe against a queue model
module tb_shifter_pipe;
   localparam int W = 32, SW = 5, TW = 5;
   logic clk = 0, rst = 0, flush_in = 0, in_valid = 0, out_ready = 1;
   logic in_ready, out_valid;
   logic [2:0] mode_in = 0;
   logic [SW-1:0] shamt_in = 0;
   logic [W-1:0] a_in = 0, out_data;
   logic [TW-1:0] tag_in = 0, out_tag;
   int errors = 0, checks = 0, pops = 0, vcount = 0, idx, n, p0;
   logic [W+TW-1:0] q[$];
   logic [W+TW-1:0] e;
   logic held = 0;
   logic [W-1:0] hd;
   logic [TW-1:0] ht;
   logic [2:0] bm [5];
   logic [SW-1:0] bs [5];
   logic [W-1:0] ba [5];

   shifter_pipe #(.WIDTH(W), .REG_EVERY(2), .TAG_W(TW)) dut (
      .clk(clk), .rst(rst), .flush_in(flush_in), .in_valid(in_valid), .in_ready(in_ready),
      .mode_in(mode_in), .shamt_in(shamt_in), .a_in(a_in), .tag_in(tag_in),
      .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_tag(out_tag)
   );

   always #5 clk = ~clk;

   function automatic logic [W-1:0] ref_shift(input logic [2:0] m, input logic [SW-1:0] s, input logic [W-1:0] a);
      logic [2*W-1:0] r, l;
      r = {a, a} >> s;
      l = {a, a} << s;
      case (m)
         3'd0: return a >> s;
         3'd1: return W'($signed(a) >>> s);
         3'd2, 3'd3: return a << s;
         3'd4: return r[W-1:0];
         3'd5: return l[2*W-1:W];
         default: return a;
      endcase
   endfunction

   task automatic chk(input string name, input logic [63:0] got, input logic [63:0] want);
      checks++;
      if (got !== want) begin
         errors++;
         $display("FAIL %s: got %h want %h at %0t", name, got, want, $time);
      end
   endtask

   always @(negedge clk) begin
      if (rst) begin
         q.delete();
         held = 0;
      end else begin
         if (held) begin
            chk("hold_valid", {63'd0, out_valid}, 64'd1);
            chk("hold_data", {32'd0, out_data}, {32'd0, hd});
            chk("hold_tag", {59'd0, out_tag}, {59'd0, ht});
         end
         if (out_valid) vcount++;
         if (out_valid && out_ready) begin
            pops++;
            if (q.size() == 0) chk("spurious_out", 64'd1, 64'd0);
            else begin
               e = q.pop_front();
               chk("model_data", {32'd0, out_data}, {32'd0, e[W+TW-1:TW]});
               chk("model_tag", {59'd0, out_tag}, {59'd0, e[TW-1:0]});
            end
         end
         held = out_valid && !out_ready && !flush_in;
         hd = out_data;
         ht = out_tag;
         if (flush_in) q.delete();
         else if (in_valid && in_ready) q.push_back({ref_shift(mode_in, shamt_in, a_in), tag_in});
      end
   end

   task automatic run_one(input logic [2:0] m, input logic [SW-1:0] s, input logic [W-1:0] a,
                          input logic [TW-1:0] t, input logic [W-1:0] want, input string name);
      chk({name, "_model"}, {32'd0, ref_shift(m, s, a)}, {32'd0, want});
      out_ready = 1;
      mode_in = m; shamt_in = s; a_in = a; tag_in = t; in_valid = 1;
      chk({name, "_in_ready"}, {63'd0, in_ready}, 64'd1);
      @(posedge clk); #1;
      in_valid = 0;
      n = 1;
      while (!out_valid && n < 10) begin
         @(posedge clk); #1;
         n++;
      end
      chk({name, "_latency"}, n, 3);
      chk({name, "_data"}, {32'd0, out_data}, {32'd0, want});
      chk({name, "_tag"}, {59'd0, out_tag}, {59'd0, t});
      @(posedge clk); #1;
   endtask

   task automatic drive_slot();
      in_valid = idx < 5;
      if (idx < 5) begin
         mode_in = bm[idx]; shamt_in = bs[idx]; a_in = ba[idx]; tag_in = TW'(idx + 10);
         if (in_ready) idx++;
      end
   endtask

   initial begin
      #1 rst = 1;
      #1;
      chk("rst_valid", {63'd0, out_valid}, 64'd0);
      chk("rst_data", {32'd0, out_data}, 64'd0);
      chk("rst_tag", {59'd0, out_tag}, 64'd0);
      chk("rst_in_ready", {63'd0, in_ready}, 64'd1);
      @(posedge clk); @(posedge clk); #1;
      rst = 0;
      run_one(3'd1, 5'd4, 32'h8000_00F0, 5'd7, 32'hF800_000F, "sra");
      run_one(3'd0, 5'd4, 32'h8000_00F0, 5'd8, 32'h0800_000F, "srl");
      run_one(3'd5, 5'd1, 32'h8000_0001, 5'd9, 32'h0000_0003, "rol");
      run_one(3'd4, 5'd31, 32'h0000_0001, 5'd10, 32'h0000_0002, "ror");
      run_one(3'd2, 5'd31, 32'hFFFF_FFFF, 5'd11, 32'h8000_0000, "sll");
      for (int m = 0; m < 8; m++) run_one(3'(m), 5'd0, 32'h1234_5678, 5'(m), 32'h1234_5678, "zero_shamt");
      run_one(3'd6, 5'd5, 32'h1234_5678, 5'd3, 32'h1234_5678, "pass6");
      run_one(3'd7, 5'd5, 32'h1234_5678, 5'd4, 32'h1234_5678, "pass7");
      // backpressure: three stages fill, then the input stalls
      for (int i = 0; i < 5; i++) begin
         bm[i] = 3'($urandom_range(0, 5)); bs[i] = 5'($urandom); ba[i] = $urandom;
      end
      idx = 0;
      out_ready = 0;
      for (int c = 0; c < 6; c++) begin
         drive_slot();
         @(posedge clk); #1;
      end
      chk("bp_accepted", idx, 3);
      chk("bp_in_ready", {63'd0, in_ready}, 64'd0);
      chk("bp_out_valid", {63'd0, out_valid}, 64'd1);
      out_ready = 1;
      p0 = pops;
      for (int c = 0; c < 5; c++) begin
         drive_slot();
         @(posedge clk); #1;
      end
      in_valid = 0;
      chk("bp_all_accepted", idx, 5);
      chk("bp_stream", pops - p0, 5);
      repeat (4) @(posedge clk);
      #1;
      // flush with two in flight and a third offered
      in_valid = 1; mode_in = 3'd2; shamt_in = 5'd1; a_in = 32'h1; tag_in = 5'd1;
      @(posedge clk); #1;
      tag_in = 5'd2;
      @(posedge clk); #1;
      tag_in = 5'd3; flush_in = 1;
      @(posedge clk); #1;
      flush_in = 0; in_valid = 0;
      vcount = 0;
      repeat (5) begin
         @(posedge clk); #1;
      end
      chk("flush_no_valid", vcount, 0);
      run_one(3'd0, 5'd8, 32'hABCD_0000, 5'd21, 32'h00AB_CD00, "after_flush");
      // async reset with three ops in flight
      out_ready = 0;
      for (int i = 0; i < 3; i++) begin
         in_valid = 1; mode_in = 3'd4; shamt_in = 5'(i + 1); a_in = $urandom | 32'h1; tag_in = 5'(i + 1);
         @(posedge clk); #1;
      end
      in_valid = 0;
      chk("pre_rst_valid", {63'd0, out_valid}, 64'd1);
      #2 rst = 1;
      #1;
      chk("arst_valid", {63'd0, out_valid}, 64'd0);
      chk("arst_data", {32'd0, out_data}, 64'd0);
      chk("arst_tag", {59'd0, out_tag}, 64'd0);
      @(posedge clk); @(posedge clk); #1;
      rst = 0;
      chk("post_rst_in_ready", {63'd0, in_ready}, 64'd1);
      out_ready = 1;
      vcount = 0;
      repeat (6) begin
         @(posedge clk); #1;
      end
      chk("post_rst_no_stale", vcount, 0);
      // randomized traffic with backpressure and occasional flush
      for (int c = 0; c < 3000; c++) begin
         in_valid = $urandom_range(0, 9) < 7;
         mode_in = 3'($urandom);
         shamt_in = 5'($urandom);
         a_in = $urandom;
         tag_in = 5'($urandom);
         out_ready = $urandom_range(0, 9) < 7;
         flush_in = $urandom_range(0, 99) < 2;
         @(posedge clk); #1;
      end
      in_valid = 0; flush_in = 0; out_ready = 1;
      repeat (8) begin
         @(posedge clk); #1;
      end
      chk("drain_empty", q.size(), 0);
      chk("drain_idle", {63'd0, out_valid}, 64'd0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
